// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared constants, text mode type and helpers for the text renderer
//
// Purpose : font cell size, blank character code, animation mode encoding and
//           two small helpers used by the render_text_anim pipeline.
// Ports   : none (package).

package render_pkg;

    localparam int         CHAR_PIXELS = 8;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        TM_STATIC     = 2'b00,
        TM_TYPE       = 2'b01,
        TM_BLINK      = 2'b10,
        TM_TYPE_BLINK = 2'b11
    } text_mode_e;

    // A scale of 0 is treated as 1 so a cleared register still draws text.
    function automatic logic [1:0] size_effective(input logic [1:0] i_size);
        return (i_size == 2'd0) ? 2'd1 : i_size;
    endfunction

    function automatic logic is_type_mode(input text_mode_e i_mode);
        return (i_mode == TM_TYPE) || (i_mode == TM_TYPE_BLINK);
    endfunction

endpackage

// File: rtl/font_rom.sv
// rtl/font_rom.sv - combinational 8x8 glyph lookup
//
// Purpose : returns one pixel of an 8x8 glyph. Row 0 is the top line, col 0 the
//           leftmost pixel. Space is blank; characters without a dedicated
//           glyph render as a hollow box so they remain visible.
// Ports   : i_char  ASCII code
//           i_row   glyph row 0..7
//           i_col   glyph column 0..7
//           o_pixel 1 = foreground

module font_rom (
    input  logic [7:0] i_char,
    input  logic [2:0] i_row,
    input  logic [2:0] i_col,
    output logic       o_pixel
);

    logic [63:0] w_glyph;
    logic [5:0]  w_bit_idx;

    // Glyphs are packed row 0 in the top byte, column 0 in the MSB of each byte.
    always_comb begin
        case (i_char)
            8'h20:   w_glyph = 64'h0000_0000_0000_0000;
            8'h30:   w_glyph = 64'h3C66_6E76_6666_3C00;
            8'h31:   w_glyph = 64'h1838_1818_1818_7E00;
            8'h41:   w_glyph = 64'h183C_6666_7E66_6600;
            8'h42:   w_glyph = 64'h7C66_667C_6666_7C00;
            8'h45:   w_glyph = 64'h7E60_607C_6060_7E00;
            8'h48:   w_glyph = 64'h6666_667E_6666_6600;
            8'h49:   w_glyph = 64'h3C18_1818_1818_3C00;
            8'h4F:   w_glyph = 64'h3C66_6666_6666_3C00;
            default: w_glyph = 64'h7E42_4242_4242_7E00;
        endcase
    end

    // Bit 63 - (8*row + col) is simply the inverted 6-bit {row, col}.
    assign w_bit_idx = ~{i_row, i_col};
    assign o_pixel   = w_glyph[w_bit_idx];

endmodule

// File: rtl/render_text_anim.sv
// rtl/render_text_anim.sv - pipelined text renderer with typewriter reveal and blink
//
// Purpose : draws one N-character string at a scaled 8x8 font position with an
//           optional border. Two-stage pixel pipeline (geometry, then font and
//           colour) with fixed 2-clock latency. Strings are double-buffered and
//           only become visible at a frame boundary.
// Ports   : clk, rst_n               pixel clock, async active-low reset
//           frame_start              1-cycle pulse per frame
//           str_valid/str_data/str_ready  string handshake (char 0 = MSB byte)
//           mode                     00 static, 01 type, 10 blink, 11 type+blink
//           x_start, y_start, size   text origin and scale (0 acts as 1)
//           color_rgb, border, border_rgb  text colour, border enable/colour
//           pix_valid, row, col      current pixel from the timing generator
//           vga_r/g/b, pix_valid_o   pixel colour and delayed valid
//           reveal_done              all characters revealed

module render_text_anim
    import render_pkg::*;
#(
    parameter int N          = 16,
    parameter int COORD_W    = 10,
    parameter int REVEAL_DIV = 4,
    parameter int BLINK_DIV  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               str_valid,
    input  logic [8*N-1:0]     str_data,
    output logic               str_ready,
    input  logic [1:0]         mode,
    input  logic [COORD_W-1:0] x_start,
    input  logic [COORD_W-1:0] y_start,
    input  logic [1:0]         size,
    input  logic [11:0]        color_rgb,
    input  logic               border,
    input  logic [11:0]        border_rgb,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic               pix_valid_o,
    output logic               reveal_done
);

    // Three extra bits keep x_start + text width + border from wrapping.
    localparam int GW   = COORD_W + 3;
    localparam int CI_W = (N > 1) ? $clog2(N) : 1;
    localparam int RC_W = $clog2(N + 1);
    localparam int FC_W = (REVEAL_DIV > 1) ? $clog2(REVEAL_DIV) : 1;
    localparam int BC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [GW-1:0]   TEXT_W1     = GW'(N * CHAR_PIXELS);
    localparam logic [GW-1:0]   TEXT_W2     = GW'(N * CHAR_PIXELS * 2);
    localparam logic [GW-1:0]   TEXT_W3     = GW'(N * CHAR_PIXELS * 3);
    localparam logic [GW-1:0]   DIV3        = GW'(3);
    localparam logic [RC_W-1:0] REVEAL_FULL = RC_W'(N);
    localparam logic [FC_W-1:0] FC_LAST     = FC_W'(REVEAL_DIV - 1);
    localparam logic [BC_W-1:0] BC_LAST     = BC_W'(BLINK_DIV - 1);

    // ------------------------------------------------------------------
    // Animation and string buffering state
    // ------------------------------------------------------------------
    logic [8*N-1:0]  r_active;
    logic [8*N-1:0]  r_pend_data;
    logic            r_pend_full;
    text_mode_e      r_mode_q;
    logic [RC_W-1:0] r_reveal_cnt;
    logic [FC_W-1:0] r_frame_cnt;
    logic [BC_W-1:0] r_blink_cnt;
    logic            r_blink_on;
    logic            r_reveal_done;

    text_mode_e      w_mode_in;
    logic            w_accept;
    logic            w_promote;
    logic            w_blink_en;
    logic [RC_W-1:0] w_reveal_nxt;
    logic [FC_W-1:0] w_frame_nxt;

    // A frame_start frees the pending slot in the same cycle, so a second
    // string can be taken while the first one is promoted.
    assign str_ready = !r_pend_full || frame_start;
    assign w_accept  = str_valid && str_ready;
    assign w_promote = frame_start && r_pend_full;
    assign w_mode_in = text_mode_e'(mode);

    always_comb begin
        w_reveal_nxt = r_reveal_cnt;
        w_frame_nxt  = r_frame_cnt;
        if (frame_start) begin
            if (!is_type_mode(w_mode_in)) begin
                w_reveal_nxt = REVEAL_FULL;
                w_frame_nxt  = '0;
            end else if (!is_type_mode(r_mode_q) || r_pend_full) begin
                // New typewriter run, or a new string arriving: start over.
                w_reveal_nxt = '0;
                w_frame_nxt  = '0;
            end else if (r_frame_cnt == FC_LAST) begin
                w_frame_nxt = '0;
                if (r_reveal_cnt != REVEAL_FULL) begin
                    w_reveal_nxt = r_reveal_cnt + RC_W'(1);
                end
            end else begin
                w_frame_nxt = r_frame_cnt + FC_W'(1);
            end
        end
    end

    // Blinking runs off the mode already in force, so the frame that switches
    // into a blink mode always shows a full visible half-period first. Leaving
    // a blink mode (new mode without the blink bit) restores visibility at once.
    assign w_blink_en = frame_start && mode[1] &&
                        ((r_mode_q == TM_BLINK) ||
                         ((r_mode_q == TM_TYPE_BLINK) && r_reveal_done));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active      <= {N{ASCII_SPACE}};
            r_pend_data   <= {N{ASCII_SPACE}};
            r_pend_full   <= 1'b0;
            r_mode_q      <= TM_STATIC;
            r_reveal_cnt  <= '0;
            r_frame_cnt   <= '0;
            r_blink_cnt   <= '0;
            r_blink_on    <= 1'b1;
            r_reveal_done <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pend_data <= str_data;
                r_pend_full <= 1'b1;
            end else if (w_promote) begin
                r_pend_full <= 1'b0;
            end

            if (w_promote) begin
                r_active <= r_pend_data;
            end

            if (frame_start) begin
                r_mode_q <= w_mode_in;
                if (w_blink_en) begin
                    if (r_blink_cnt == BC_LAST) begin
                        r_blink_cnt <= '0;
                        r_blink_on  <= !r_blink_on;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + BC_W'(1);
                    end
                end else begin
                    r_blink_cnt <= '0;
                    r_blink_on  <= 1'b1;
                end
            end

            r_reveal_cnt  <= w_reveal_nxt;
            r_frame_cnt   <= w_frame_nxt;
            r_reveal_done <= (w_reveal_nxt == REVEAL_FULL);
        end
    end

    assign reveal_done = r_reveal_done;

    // ------------------------------------------------------------------
    // S1: geometry
    // ------------------------------------------------------------------
    logic [1:0]    w_size_eff;
    logic [GW-1:0] w_sz, w_col, w_row, w_x, w_y;
    logic [GW-1:0] w_text_w, w_text_h, w_x_end, w_y_end;
    logic [GW-1:0] w_bx0, w_by0, w_bx1, w_by1;
    logic [GW-1:0] w_rel_x, w_rel_y, w_px, w_py;
    logic          w_in_text, w_in_border;

    always_comb begin
        w_size_eff = size_effective(size);
        w_sz       = GW'(w_size_eff);
        w_col      = GW'(col);
        w_row      = GW'(row);
        w_x        = GW'(x_start);
        w_y        = GW'(y_start);

        case (w_size_eff)
            2'd2:    w_text_w = TEXT_W2;
            2'd3:    w_text_w = TEXT_W3;
            default: w_text_w = TEXT_W1;
        endcase
        w_text_h = w_sz << 3;
        w_x_end  = w_x + w_text_w;
        w_y_end  = w_y + w_text_h;

        // Border is size_eff pixels thick; its left/top edge stops at 0.
        w_bx0 = (w_x >= w_sz) ? (w_x - w_sz) : '0;
        w_by0 = (w_y >= w_sz) ? (w_y - w_sz) : '0;
        w_bx1 = w_x_end + w_sz;
        w_by1 = w_y_end + w_sz;

        w_in_text   = (w_col >= w_x) && (w_col < w_x_end) &&
                      (w_row >= w_y) && (w_row < w_y_end);
        w_in_border = border && !w_in_text &&
                      (w_col >= w_bx0) && (w_col < w_bx1) &&
                      (w_row >= w_by0) && (w_row < w_by1);

        // Unscaled font-space coordinates; only meaningful inside the text box.
        w_rel_x = w_col - w_x;
        w_rel_y = w_row - w_y;
        case (w_size_eff)
            2'd2: begin
                w_px = w_rel_x >> 1;
                w_py = w_rel_y >> 1;
            end
            2'd3: begin
                w_px = w_rel_x / DIV3;
                w_py = w_rel_y / DIV3;
            end
            default: begin
                w_px = w_rel_x;
                w_py = w_rel_y;
            end
        endcase
    end

    logic            r_s1_valid;
    logic            r_s1_in_text;
    logic            r_s1_in_border;
    logic [CI_W-1:0] r_s1_char_idx;
    logic [2:0]      r_s1_font_row;
    logic [2:0]      r_s1_font_col;
    logic [11:0]     r_s1_color;
    logic [11:0]     r_s1_border_rgb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid      <= 1'b0;
            r_s1_in_text    <= 1'b0;
            r_s1_in_border  <= 1'b0;
            r_s1_char_idx   <= '0;
            r_s1_font_row   <= '0;
            r_s1_font_col   <= '0;
            r_s1_color      <= '0;
            r_s1_border_rgb <= '0;
        end else begin
            r_s1_valid      <= pix_valid;
            r_s1_in_text    <= w_in_text;
            r_s1_in_border  <= w_in_border;
            r_s1_char_idx   <= CI_W'(w_px >> 3);
            r_s1_font_row   <= 3'(w_py);
            r_s1_font_col   <= 3'(w_px);
            r_s1_color      <= color_rgb;
            r_s1_border_rgb <= border_rgb;
        end
    end

    // ------------------------------------------------------------------
    // S2: font lookup and colour mux
    // ------------------------------------------------------------------
    logic [7:0]  w_char;
    logic        w_font_pix;
    logic        w_text_on;
    logic [11:0] r_rgb;
    logic        r_pix_valid_o;

    always_comb begin
        w_char = r_active[8*(N-1-int'(r_s1_char_idx)) +: 8];
    end

    font_rom u_font_rom (
        .i_char  (w_char),
        .i_row   (r_s1_font_row),
        .i_col   (r_s1_font_col),
        .o_pixel (w_font_pix)
    );

    assign w_text_on = r_s1_in_text && (RC_W'(r_s1_char_idx) < r_reveal_cnt) &&
                       w_font_pix && r_blink_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb         <= '0;
            r_pix_valid_o <= 1'b0;
        end else begin
            r_pix_valid_o <= r_s1_valid;
            if (!r_s1_valid) begin
                r_rgb <= '0;
            end else if (w_text_on) begin
                r_rgb <= r_s1_color;
            end else if (r_s1_in_border) begin
                r_rgb <= r_s1_border_rgb;
            end else begin
                r_rgb <= '0;
            end
        end
    end

    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];
    assign pix_valid_o = r_pix_valid_o;

endmodule

// File: tb/tb_render_text_anim.sv
// tb/tb_render_text_anim.sv - directed self-checking bench for render_text_anim

module tb_render_text_anim;

    localparam int N       = 16;
    localparam int COORD_W = 10;

    localparam logic [11:0] TXT = 12'hF80;
    localparam logic [11:0] BRD = 12'h0AF;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               frame_start;
    logic               str_valid;
    logic [8*N-1:0]     str_data;
    logic               str_ready;
    logic [1:0]         mode;
    logic [COORD_W-1:0] x_start, y_start;
    logic [1:0]         size;
    logic [11:0]        color_rgb, border_rgb;
    logic               border;
    logic               pix_valid;
    logic [COORD_W-1:0] row, col;
    logic [3:0]         vga_r, vga_g, vga_b;
    logic               pix_valid_o;
    logic               reveal_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Hand-written 8x8 'A': 18 3C 66 66 7E 66 66 00
    logic [63:0] glyph_a = 64'h183C_6666_7E66_6600;

    always #5 clk = ~clk;

    render_text_anim #(
        .N(N), .COORD_W(COORD_W), .REVEAL_DIV(4), .BLINK_DIV(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .str_valid(str_valid), .str_data(str_data), .str_ready(str_ready),
        .mode(mode), .x_start(x_start), .y_start(y_start), .size(size),
        .color_rgb(color_rgb), .border(border), .border_rgb(border_rgb),
        .pix_valid(pix_valid), .row(row), .col(col),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .pix_valid_o(pix_valid_o), .reveal_done(reveal_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int r, input int c, output logic [11:0] rgb);
        pix_valid = 1'b1;
        row = 10'(r);
        col = 10'(c);
        tick;
        tick;
        rgb = {vga_r, vga_g, vga_b};
    endtask

    task automatic frame;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
    endtask

    task automatic load(input logic [8*N-1:0] s);
        str_valid = 1'b1;
        str_data  = s;
        tick;
        str_valid = 1'b0;
    endtask

    function automatic logic [8*N-1:0] str_of(input logic [7:0] c0, input logic [7:0] rest);
        logic [8*N-1:0] s;
        s = {N{rest}};
        s[8*N-1 -: 8] = c0;
        return s;
    endfunction

    task automatic test_reset;
        logic [11:0] got;
        rst_n = 1'b0; frame_start = 0; str_valid = 0; str_data = '0; mode = 2'b00;
        x_start = 0; y_start = 0; size = 2'd1; color_rgb = TXT; border = 0;
        border_rgb = BRD; pix_valid = 0; row = 0; col = 0;
        tick; tick;
        n_tests++;
        if ({vga_r, vga_g, vga_b, pix_valid_o} !== 13'h0) begin
            n_fail++; $display("FAIL reset_out: got %h want 0", {vga_r, vga_g, vga_b, pix_valid_o});
        end
        n_tests++;
        if (str_ready !== 1'b1 || reveal_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: ready=%b done=%b want ready=1 done=0", str_ready, reveal_done);
        end
        rst_n = 1'b1;
        tick;
        frame;
        n_tests++;
        if (reveal_done !== 1'b1) begin
            n_fail++; $display("FAIL static_done: got %b want 1", reveal_done);
        end
        pix(0, 3, got);
        n_tests++;
        if (got !== 12'h000) begin
            n_fail++; $display("FAIL reset_spaces: got %h want 000", got);
        end
    endtask

    task automatic test_static_font;
        logic [11:0] got, exp;
        load(str_of(8'h41, 8'h20));
        frame;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 9; c++) begin
                pix(r, c, got);
                exp = 12'h000;
                if (c < 8) if (glyph_a[63-8*r-c]) exp = TXT;
                n_tests++;
                if (got !== exp) begin
                    n_fail++; $display("FAIL static r%0d c%0d: got %h want %h", r, c, got, exp);
                end
            end
        end
        n_tests++;
        if (pix_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL pv_high: got %b want 1", pix_valid_o);
        end
        // Latency: (0,0) is off, (0,3) is on; output must change on the 2nd clock only.
        pix(0, 0, got);
        col = 10'd3;
        tick;
        n_tests++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            n_fail++; $display("FAIL latency_1clk: got %h want 000", {vga_r, vga_g, vga_b});
        end
        tick;
        n_tests++;
        if ({vga_r, vga_g, vga_b} !== TXT) begin
            n_fail++; $display("FAIL latency_2clk: got %h want %h", {vga_r, vga_g, vga_b}, TXT);
        end
        pix_valid = 1'b0;
        tick;
        n_tests++;
        if (pix_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL pv_lag: got %b want 1", pix_valid_o);
        end
        tick;
        n_tests++;
        if (pix_valid_o !== 1'b0 || {vga_r, vga_g, vga_b} !== 12'h000) begin
            n_fail++; $display("FAIL pv_low: pv=%b rgb=%h want pv=0 rgb=000", pix_valid_o, {vga_r, vga_g, vga_b});
        end
    endtask

    task automatic test_border_scale;
        int          vr[17] = '{10, 10, 5, 5, 5, 5, 5, 5, 7, 8, 8, 2, 1, 29, 32, 31, 28};
        int          vc[17] = '{2, 1, 388, 389, 391, 392, 14, 13, 19, 11, 10, 100, 100, 10, 10, 10, 4};
        logic [11:0] ve[17] = '{BRD, 12'h0, 12'h0, BRD, BRD, 12'h0, TXT, 12'h0, TXT, TXT,
                                12'h0, BRD, 12'h0, BRD, 12'h0, BRD, BRD};
        logic [11:0] got;
        size = 2'd3; border = 1'b1; x_start = 10'd5; y_start = 10'd5;
        for (int i = 0; i < 17; i++) begin
            pix(vr[i], vc[i], got);
            n_tests++;
            if (got !== ve[i]) begin
                n_fail++; $display("FAIL border r%0d c%0d: got %h want %h", vr[i], vc[i], got, ve[i]);
            end
        end
        // Box left/top edge clamps at 0 instead of wrapping.
        x_start = 10'd1; y_start = 10'd1;
        pix(10, 0, got);
        n_tests++;
        if (got !== BRD) begin
            n_fail++; $display("FAIL clamp_x: got %h want %h", got, BRD);
        end
        pix(0, 0, got);
        n_tests++;
        if (got !== BRD) begin
            n_fail++; $display("FAIL clamp_xy: got %h want %h", got, BRD);
        end
    endtask

    task automatic test_size_zero;
        logic [11:0] got, exp;
        size = 2'd0; border = 1'b0; x_start = 0; y_start = 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 9; c++) begin
                pix(r, c, got);
                exp = 12'h000;
                if (c < 8) if (glyph_a[63-8*r-c]) exp = TXT;
                n_tests++;
                if (got !== exp) begin
                    n_fail++; $display("FAIL size0 r%0d c%0d: got %h want %h", r, c, got, exp);
                end
            end
        end
        size = 2'd1;
    endtask

    task automatic test_typewriter;
        logic [11:0] got;
        load(str_of(8'h49, 8'h49));
        mode = 2'b01;
        frame;
        n_tests++;
        if (reveal_done !== 1'b0) begin
            n_fail++; $display("FAIL tw_start_done: got %b want 0", reveal_done);
        end
        pix(0, 2, got);
        n_tests++;
        if (got !== 12'h000) begin
            n_fail++; $display("FAIL tw_reveal0: got %h want 000", got);
        end
        repeat (3) frame;
        pix(0, 2, got);
        n_tests++;
        if (got !== 12'h000) begin
            n_fail++; $display("FAIL tw_3frames: got %h want 000", got);
        end
        frame;
        pix(0, 2, got);
        n_tests++;
        if (got !== TXT) begin
            n_fail++; $display("FAIL tw_char0: got %h want %h", got, TXT);
        end
        pix(0, 10, got);
        n_tests++;
        if (got !== 12'h000) begin
            n_fail++; $display("FAIL tw_char1_blank: got %h want 000", got);
        end
        repeat (56) frame;
        pix(0, 114, got);
        n_tests++;
        if (got !== TXT) begin
            n_fail++; $display("FAIL tw_char14: got %h want %h", got, TXT);
        end
        pix(0, 122, got);
        n_tests++;
        if (got !== 12'h000 || reveal_done !== 1'b0) begin
            n_fail++; $display("FAIL tw_char15_blank: got %h done=%b want 000 done=0", got, reveal_done);
        end
        repeat (3) frame;
        n_tests++;
        if (reveal_done !== 1'b0) begin
            n_fail++; $display("FAIL tw_early_done: got %b want 0", reveal_done);
        end
        frame;
        n_tests++;
        if (reveal_done !== 1'b1) begin
            n_fail++; $display("FAIL tw_done: got %b want 1", reveal_done);
        end
        pix(0, 122, got);
        n_tests++;
        if (got !== TXT) begin
            n_fail++; $display("FAIL tw_char15: got %h want %h", got, TXT);
        end
        repeat (4) frame;
        n_tests++;
        if (reveal_done !== 1'b1) begin
            n_fail++; $display("FAIL tw_done_hold: got %b want 1", reveal_done);
        end
    endtask

    task automatic test_blink;
        logic [11:0] got, exp;
        mode = 2'b10; border = 1'b1;
        for (int f = 0; f < 6; f++) begin
            frame;
            exp = (f == 2 || f == 3) ? 12'h000 : TXT;
            pix(0, 2, got);
            n_tests++;
            if (got !== exp) begin
                n_fail++; $display("FAIL blink_text f%0d: got %h want %h", f, got, exp);
            end
            pix(0, 128, got);
            n_tests++;
            if (got !== BRD) begin
                n_fail++; $display("FAIL blink_border f%0d: got %h want %h", f, got, BRD);
            end
        end
        mode = 2'b00; border = 1'b0;
        frame;
        pix(0, 2, got);
        n_tests++;
        if (got !== TXT) begin
            n_fail++; $display("FAIL blink_exit: got %h want %h", got, TXT);
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] got;
        pix(0, 1, got);
        n_tests++;
        if (got !== 12'h000) begin
            n_fail++; $display("FAIL hs_old_active: got %h want 000", got);
        end
        str_valid = 1'b1;
        str_data  = str_of(8'h42, 8'h42);
        #1;
        n_tests++;
        if (str_ready !== 1'b1) begin
            n_fail++; $display("FAIL hs_ready_s1: got %b want 1", str_ready);
        end
        tick;
        str_data = str_of(8'h48, 8'h48);
        tick; tick;
        n_tests++;
        if (str_ready !== 1'b0) begin
            n_fail++; $display("FAIL hs_ready_full: got %b want 0", str_ready);
        end
        pix(0, 1, got);
        n_tests++;
        if (got !== 12'h000) begin
            n_fail++; $display("FAIL hs_not_yet: got %h want 000", got);
        end
        frame_start = 1'b1;
        #1;
        n_tests++;
        if (str_ready !== 1'b1) begin
            n_fail++; $display("FAIL hs_ready_fs: got %b want 1", str_ready);
        end
        tick;
        frame_start = 1'b0;
        str_valid   = 1'b0;
        #1;
        n_tests++;
        if (str_ready !== 1'b0) begin
            n_fail++; $display("FAIL hs_s2_pending: got %b want 0", str_ready);
        end
        pix(0, 1, got);
        n_tests++;
        if (got !== TXT) begin
            n_fail++; $display("FAIL hs_s1_c1: got %h want %h", got, TXT);
        end
        pix(0, 4, got);
        n_tests++;
        if (got !== TXT) begin
            n_fail++; $display("FAIL hs_s1_c4: got %h want %h", got, TXT);
        end
        frame;
        pix(0, 4, got);
        n_tests++;
        if (got !== 12'h000) begin
            n_fail++; $display("FAIL hs_s2_c4: got %h want 000", got);
        end
        pix(0, 1, got);
        n_tests++;
        if (got !== TXT || str_ready !== 1'b1) begin
            n_fail++; $display("FAIL hs_s2_c1: got %h ready=%b want %h ready=1", got, str_ready, TXT);
        end
    endtask

    task automatic test_reset_mid;
        logic [11:0] got;
        mode = 2'b01;
        frame;
        repeat (4) frame;
        pix(0, 1, got);
        n_tests++;
        if (got !== TXT) begin
            n_fail++; $display("FAIL rm_before: got %h want %h", got, TXT);
        end
        tick;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({vga_r, vga_g, vga_b} !== 12'h000 || pix_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rm_async: rgb=%h pv=%b want 000 0", {vga_r, vga_g, vga_b}, pix_valid_o);
        end
        n_tests++;
        if (reveal_done !== 1'b0 || str_ready !== 1'b1) begin
            n_fail++; $display("FAIL rm_flags: done=%b ready=%b want 0 1", reveal_done, str_ready);
        end
        tick; tick;
        rst_n = 1'b1;
        tick;
        n_tests++;
        if (pix_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rm_pv_1clk: got %b want 0", pix_valid_o);
        end
        tick;
        n_tests++;
        if (pix_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL rm_pv_2clk: got %b want 1", pix_valid_o);
        end
        mode = 2'b00;
        frame;
        pix(0, 1, got);
        n_tests++;
        if (got !== 12'h000 || reveal_done !== 1'b1) begin
            n_fail++; $display("FAIL rm_spaces: got %h done=%b want 000 1", got, reveal_done);
        end
    endtask

    initial begin
        test_reset;
        test_static_font;
        test_border_scale;
        test_size_zero;
        test_typewriter;
        test_blink;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
